// File: rtl/img_pkg.sv
// Shared image-pipeline types and widths, plus small Sobel arithmetic helpers.
package img_pkg;
   localparam int PIX_W  = 8;
   localparam int GRAD_W = 11;
   localparam int MAG_W  = 12;

   typedef logic [PIX_W-1:0] pixel_t;

   // Zero-extend an unsigned pixel into the signed gradient domain.
   function automatic logic signed [GRAD_W-1:0] widen(input pixel_t p);
      return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
   endfunction

   function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
      logic [GRAD_W-1:0] a;
      a = g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
      return MAG_W'(a);
   endfunction
endpackage

// File: rtl/line_buffer.sv
// Single-port row store: combinational read, synchronous write, old data seen on same-address write.
module line_buffer #(
   parameter int DEPTH = 317,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end
endmodule

// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel edge detector over a raster-order gray stream, two rows buffered.
module gray_sobel
   import img_pkg::*;
#(
   parameter int W      = 317,
   parameter int H      = 391,
   parameter int THRESH = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_data,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_data,
   output logic             out_eof
);
   localparam int COL_W = $clog2(W);
   localparam int ROW_W = $clog2(H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);

   logic [COL_W-1:0] col_reg, col_next, beat_col;
   logic [ROW_W-1:0] row_reg, row_next, beat_row;

   pixel_t lb0_rdata, lb1_rdata;
   pixel_t win_reg [3][3];
   pixel_t new_col [3];

   logic win_valid_reg, win_eof_reg;
   logic signed [GRAD_W-1:0] gx_reg, gy_reg, gx_next, gy_next;
   logic g_valid_reg, g_eof_reg;
   logic [MAG_W-1:0] mag;
   pixel_t out_data_reg, out_data_next;
   logic out_valid_reg, out_eof_reg;

   // Start-of-frame overrides the running position for this beat only.
   always_comb begin
      beat_col = in_sof ? '0 : col_reg;
      beat_row = in_sof ? '0 : row_reg;
      col_next = col_reg;
      row_next = row_reg;
      if (in_valid) begin
         if (beat_col == COL_LAST) begin
            col_next = '0;
            row_next = (beat_row == ROW_LAST) ? '0 : beat_row + ROW_W'(1);
         end else begin
            col_next = beat_col + COL_W'(1);
            row_next = beat_row;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_reg <= '0;
         row_reg <= '0;
      end else begin
         col_reg <= col_next;
         row_reg <= row_next;
      end
   end

   // lb1 holds the previous row, lb0 the row before that.
   line_buffer #(.DEPTH(W), .WIDTH(PIX_W)) u_lb0 (
      .clk   (clk),
      .we    (in_valid),
      .addr  (beat_col),
      .wdata (lb1_rdata),
      .rdata (lb0_rdata)
   );

   line_buffer #(.DEPTH(W), .WIDTH(PIX_W)) u_lb1 (
      .clk   (clk),
      .we    (in_valid),
      .addr  (beat_col),
      .wdata (in_data),
      .rdata (lb1_rdata)
   );

   assign new_col[0] = lb0_rdata;
   assign new_col[1] = lb1_rdata;
   assign new_col[2] = in_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_reg[r][c] <= '0;
            end
         end
         win_valid_reg <= 1'b0;
         win_eof_reg   <= 1'b0;
      end else begin
         if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
               win_reg[r][0] <= win_reg[r][1];
               win_reg[r][1] <= win_reg[r][2];
               win_reg[r][2] <= new_col[r];
            end
         end
         win_valid_reg <= in_valid && (beat_row >= ROW_W'(2)) && (beat_col >= COL_W'(2));
         win_eof_reg   <= (beat_row == ROW_LAST) && (beat_col == COL_LAST);
      end
   end

   always_comb begin
      gx_next = (widen(win_reg[0][2]) + (widen(win_reg[1][2]) <<< 1) + widen(win_reg[2][2]))
              - (widen(win_reg[0][0]) + (widen(win_reg[1][0]) <<< 1) + widen(win_reg[2][0]));
      gy_next = (widen(win_reg[2][0]) + (widen(win_reg[2][1]) <<< 1) + widen(win_reg[2][2]))
              - (widen(win_reg[0][0]) + (widen(win_reg[0][1]) <<< 1) + widen(win_reg[0][2]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gx_reg      <= '0;
         gy_reg      <= '0;
         g_valid_reg <= 1'b0;
         g_eof_reg   <= 1'b0;
      end else begin
         gx_reg      <= gx_next;
         gy_reg      <= gy_next;
         g_valid_reg <= win_valid_reg;
         g_eof_reg   <= win_valid_reg && win_eof_reg;
      end
   end

   // THRESH of zero means saturated magnitude; otherwise a binary edge map.
   always_comb begin
      mag = abs_grad(gx_reg) + abs_grad(gy_reg);
      out_data_next = '0;
      if (THRESH == 0) begin
         out_data_next = (mag > MAG_W'(255)) ? '1 : mag[PIX_W-1:0];
      end else begin
         out_data_next = (mag >= MAG_W'(THRESH)) ? '1 : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_eof_reg   <= 1'b0;
      end else begin
         out_data_reg  <= out_data_next;
         out_valid_reg <= g_valid_reg;
         out_eof_reg   <= g_valid_reg && g_eof_reg;
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_eof   = out_eof_reg;
endmodule

// File: tb/tb_gray_sobel.sv
// Bench for gray_sobel: four threshold variants share one stream, scored against a Sobel model.
module tb_gray_sobel;
   localparam int W = 8;
   localparam int H = 6;
   localparam int TH [4] = '{0, 50, 80, 90};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sof = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       ov [4];
   logic [7:0] od [4];
   logic       oe [4];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   gray_sobel #(.W(W), .H(H), .THRESH(0)) u_t0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov[0]), .out_data(od[0]), .out_eof(oe[0]));
   gray_sobel #(.W(W), .H(H), .THRESH(50)) u_t50 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov[1]), .out_data(od[1]), .out_eof(oe[1]));
   gray_sobel #(.W(W), .H(H), .THRESH(80)) u_t80 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov[2]), .out_data(od[2]), .out_eof(oe[2]));
   gray_sobel #(.W(W), .H(H), .THRESH(90)) u_t90 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov[3]), .out_data(od[3]), .out_eof(oe[3]));

   typedef struct {
      int              cyc;
      logic [3:0][7:0] d;
      logic            eof;
   } exp_t;

   typedef struct {
      int         kind;
      bit         thr;
      logic [7:0] e [4];
   } vec_t;

   exp_t sb [$];
   int total = 0;
   int bad = 0;
   int n_out = 0, n_eof = 0, n_sat = 0;
   int n_ne [4];
   logic [7:0] cur_e [4];

   logic [7:0] img [H][W];
   int mr = 0, mc = 0;

   function automatic void chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [7:0] shape(int mag, int th);
      if (th == 0) return (mag > 255) ? 8'd255 : 8'(mag);
      return (mag >= th) ? 8'd255 : 8'd0;
   endfunction

   function automatic logic [7:0] pix(int kind, int r, int c, int seed);
      case (kind)
         0: return 8'd100;
         1: return 8'(c * 10);
         2: return 8'(r * 10);
         3: return 8'(c * 30);
         4: return (c < 4) ? 8'd0 : 8'd200;
         default: return 8'(((r * 73) ^ (c * 151) ^ (seed * 29)) + r * c * 17);
      endcase
   endfunction

   task automatic clear_stats();
      n_out = 0; n_eof = 0; n_sat = 0;
      for (int k = 0; k < 4; k++) n_ne[k] = 0;
   endtask

   task automatic send_beat(input logic [7:0] d, input bit sof);
      exp_t e;
      int gx, gy, mag, r, c;
      @(posedge clk); #1;
      in_valid = 1'b1; in_sof = sof; in_data = d;
      if (sof) begin mr = 0; mc = 0; end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
         r = mr; c = mc;
         gx = (int'(img[r-2][c]) + 2 * int'(img[r-1][c]) + int'(img[r][c]))
            - (int'(img[r-2][c-2]) + 2 * int'(img[r-1][c-2]) + int'(img[r][c-2]));
         gy = (int'(img[r][c-2]) + 2 * int'(img[r][c-1]) + int'(img[r][c]))
            - (int'(img[r-2][c-2]) + 2 * int'(img[r-2][c-1]) + int'(img[r-2][c]));
         mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         e.cyc = cyc + 3;
         for (int k = 0; k < 4; k++) e.d[k] = shape(mag, TH[k]);
         e.eof = (r == H - 1) && (c == W - 1);
         sb.push_back(e);
      end
      mc++;
      if (mc == W) begin mc = 0; mr++; if (mr == H) mr = 0; end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0; in_sof = 1'b0;
      end
   endtask

   task automatic send_frame(input int kind, input int seed, input int nbeats,
                             input bit throttle, input bit first_sof);
      for (int i = 0; i < nbeats; i++) begin
         if (throttle) idle($urandom_range(0, 2));
         send_beat(pix(kind, i / W, i % W, seed), first_sof && (i == 0));
      end
   endtask

   task automatic drain();
      int t;
      idle(1);
      t = 0;
      while (sb.size() > 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", sb.size(), 0);
      sb.delete();
      idle(3);
   endtask

   // Output monitor: every out_valid pops one expected record.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         chk("missing_out_at_cycle", 0, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (ov[0] || ov[1] || ov[2] || ov[3]) begin
         n_out++;
         chk("valid_agree", {ov[0], ov[1], ov[2], ov[3]}, 4'hF);
         if (sb.size() == 0) begin
            chk("unexpected_out", od[0], -1);
         end else begin
            e = sb.pop_front();
            chk("out_cycle", cyc, e.cyc);
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("data_th%0d", TH[k]), od[k], e.d[k]);
               chk($sformatf("eof_th%0d", TH[k]), oe[k], e.eof);
            end
         end
         n_eof += oe[0];
         if (od[0] == 8'd255) n_sat++;
         for (int k = 0; k < 4; k++) if (od[k] != cur_e[k]) n_ne[k]++;
      end
   end

   vec_t vt [5];

   initial begin
      vt[0] = '{kind: 0, thr: 1'b0, e: '{8'd0,  8'd0,   8'd0,   8'd0}};
      vt[1] = '{kind: 1, thr: 1'b0, e: '{8'd80, 8'd255, 8'd255, 8'd0}};
      vt[2] = '{kind: 2, thr: 1'b0, e: '{8'd80, 8'd255, 8'd255, 8'd0}};
      vt[3] = '{kind: 3, thr: 1'b0, e: '{8'd240, 8'd255, 8'd255, 8'd255}};
      vt[4] = '{kind: 1, thr: 1'b1, e: '{8'd80, 8'd255, 8'd255, 8'd0}};
      for (int k = 0; k < 4; k++) cur_e[k] = 8'd0;
      clear_stats();

      // Reset state
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_valid_%0d", k), ov[k], 0);
         chk($sformatf("rst_data_%0d", k), od[k], 0);
         chk($sformatf("rst_eof_%0d", k), oe[k], 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // Uniform-result images from the table
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) cur_e[k] = vt[i].e[k];
         clear_stats();
         send_frame(vt[i].kind, 0, W * H, vt[i].thr, 1'b1);
         drain();
         chk($sformatf("tab%0d_count", i), n_out, (H - 2) * (W - 2));
         chk($sformatf("tab%0d_eofs", i), n_eof, 1);
         for (int k = 0; k < 4; k++)
            chk($sformatf("tab%0d_const_th%0d", i, TH[k]), n_ne[k], 0);
         $display("table vector %0d kind=%0d throttled=%0d outputs=%0d", i, vt[i].kind, vt[i].thr, n_out);
      end

      // Vertical step: only centres in columns 3 and 4 saturate
      clear_stats();
      send_frame(4, 0, W * H, 1'b0, 1'b1);
      drain();
      chk("step_count", n_out, 24);
      chk("step_sat", n_sat, 8);
      $display("step image outputs=%0d saturated=%0d", n_out, n_sat);

      // Textured image with random gaps
      clear_stats();
      send_frame(5, 1, W * H, 1'b1, 1'b1);
      drain();
      chk("noise_thr_count", n_out, 24);
      chk("noise_thr_eofs", n_eof, 1);
      $display("throttled textured frame outputs=%0d", n_out);

      // Reset mid-frame: outputs must drop asynchronously and nothing stale follows
      clear_stats();
      send_frame(5, 2, 20, 1'b0, 1'b1);
      idle(1);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
      sb.delete(); mr = 0; mc = 0;
      #1;
      chk("midrst_valid_async", {ov[0], ov[1], ov[2], ov[3]}, 0);
      @(negedge clk);
      chk("midrst_valid_held", {ov[0], ov[1], ov[2], ov[3]}, 0);
      chk("midrst_data_held", od[0], 0);
      idle(2);
      rst = 1'b0;
      idle(1);
      clear_stats();
      send_frame(5, 7, W * H, 1'b0, 1'b0);
      drain();
      chk("postrst_count", n_out, 24);
      chk("postrst_eofs", n_eof, 1);
      $display("frame after mid-frame reset outputs=%0d", n_out);

      // Back-to-back frames, then an early start-of-frame at beat 30
      clear_stats();
      send_frame(5, 3, W * H, 1'b0, 1'b1);
      send_frame(4, 0, W * H, 1'b0, 1'b1);
      send_frame(5, 9, 30, 1'b0, 1'b1);
      send_frame(5, 11, W * H, 1'b0, 1'b1);
      drain();
      chk("b2b_count", n_out, 24 + 24 + 10 + 24);
      chk("b2b_eofs", n_eof, 3);
      $display("back-to-back plus early sof outputs=%0d eofs=%0d", n_out, n_eof);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0d required=0", 1);
      $fatal(1, "timeout");
   end
endmodule
